barrett_sched: RTL and testbench

Shared-resource scheduler for the single Barrett reduction pipeline (bart_red) in the polynomial-arithmetic datapath. It arbitrates round-robin between N requesters that each present 16-bit operands. It drives the non-stallable reduction pipeline and tracks each in-flight operand with a tag shift register. Results are returned through an output FIFO with valid/ready, tagged with the requester ID. Credit-based issue guarantees the FIFO never overflows, so backpressure on the response side never corrupts the pipeline.

---
 rtl/barrett_sched_if.sv | 24 ++
 rtl/barrett_sched.sv | 147 ++++++++++++++
 tb/tb_barrett_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrett_sched_if.sv
// Request/response bundle between the requesters, barrett_sched and the response consumer.
// The scheduler takes the slave side; requesters and the consumer take the master side.
interface barrett_sched_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
);
    logic [N-1:0]    req_valid;
    logic [16*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [15:0]     rsp_data;
    logic [ID_W-1:0] rsp_id;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/barrett_sched.sv
// Round-robin scheduler for the shared Barrett reduction pipeline: credit-limited issue,
// tag shift register aligned with the pipeline, and a tagged output FIFO.
module barrett_sched #(
    parameter int unsigned N       = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned LAT     = 6,
    parameter int unsigned DEPTH   = 8,
    parameter logic [15:0] Q       = 16'd3329,
    parameter bit          CORRECT = 1'b1
) (
    input  logic           clk,
    input  logic           srst_n,
    barrett_sched_if.slave bus,
    output logic [15:0]    br_din,
    output logic           br_srst,
    input  logic [15:0]    br_dout,
    output logic           busy
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [CW-1:0]   credit_q, credit_d;
    logic [15:0]     din_q;
    logic [LAT-1:0]  tag_vld_q;
    logic [ID_W-1:0] tag_id_q [LAT];

    logic [15:0]     fifo_data_q [DEPTH];
    logic [ID_W-1:0] fifo_id_q   [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d;

    logic [2*N-1:0]  req_dbl;
    logic [ID_W:0]   sel_sum;
    logic            found;
    logic [ID_W-1:0] grant_idx;
    logic [N-1:0]    grant;
    logic [15:0]     sel_data;
    logic            can_issue;
    logic            issue;
    logic [15:0]     result;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Rotate the requests so the pointer lands on bit 0, then take the first set bit.
    always_comb begin
        req_dbl = {bus.req_valid, bus.req_valid} >> ptr_q;
        found   = 1'b0;
        sel_sum = '0;
        for (int j = 0; j < N; j++) begin
            if (!found && req_dbl[j]) begin
                found   = 1'b1;
                sel_sum = {1'b0, ptr_q} + (ID_W + 1)'(j);
            end
        end
        if (32'(sel_sum) >= N) begin
            sel_sum = sel_sum - (ID_W + 1)'(N);
        end
        grant_idx = sel_sum[ID_W-1:0];
        grant     = found ? (N'(1) << grant_idx) : '0;
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = bus.req_data[16*i +: 16];
            end
        end
    end

    // Credit covers both in-flight tags and buffered entries, so a push never finds the FIFO full.
    assign can_issue     = (credit_q < CW'(DEPTH));
    assign bus.req_ready = (srst_n && can_issue) ? grant : '0;
    assign issue         = |(bus.req_valid & bus.req_ready);

    always_comb begin
        result = br_dout;
        if (CORRECT && (br_dout >= Q)) begin
            result = br_dout - Q;
        end
    end

    assign fifo_push     = tag_vld_q[LAT-1];
    assign fifo_full     = (count_q == CW'(DEPTH));
    assign bus.rsp_valid = srst_n && (count_q != '0);
    assign fifo_pop      = bus.rsp_valid && bus.rsp_ready;
    assign bus.rsp_data  = bus.rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.rsp_id    = bus.rsp_valid ? fifo_id_q[rd_ptr_q] : '0;

    always_comb begin
        ptr_d    = ptr_q;
        if (issue) begin
            ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
        credit_d = credit_q + CW'(issue) - CW'(fifo_pop);
        count_d  = count_q + CW'(fifo_push) - CW'(fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            ptr_q     <= '0;
            credit_q  <= '0;
            din_q     <= '0;
            tag_vld_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            credit_q     <= credit_d;
            din_q        <= issue ? sel_data : 16'd0;
            tag_vld_q[0] <= issue;
            for (int s = 1; s < LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
            end
            if (fifo_push) begin
                wr_ptr_q <= wrap_inc(wr_ptr_q);
            end
            if (fifo_pop) begin
                rd_ptr_q <= wrap_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: validity lives in tag_vld_q and count_q.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= grant_idx;
        for (int s = 1; s < LAT; s++) begin
            tag_id_q[s] <= tag_id_q[s-1];
        end
        if (fifo_push) begin
            fifo_data_q[wr_ptr_q] <= result;
            fifo_id_q[wr_ptr_q]   <= tag_id_q[LAT-1];
        end
    end

    assign br_din  = din_q;
    assign br_srst = ~srst_n;
    assign busy    = srst_n && ((|tag_vld_q) || (count_q != '0));
endmodule

// File: tb/tb_barrett_sched.sv
// Bench for barrett_sched: two instances (CORRECT=1 and CORRECT=0) in lockstep, a pipeline
// model that reduces mod 2Q, a queue-based response model, vector table and directed sequences.
module tb_barrett_sched;
    localparam int N     = 4;
    localparam int ID_W  = 2;
    localparam int LAT   = 6;
    localparam int DEPTH = 8;
    localparam int Q     = 3329;

    logic        clk = 1'b0;
    logic        srst_n;
    logic [15:0] br_din0, br_din1, br_dout0, br_dout1;
    logic        br_srst0, br_srst1, busy0, busy1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pops = 0;

    barrett_sched_if #(.N(N), .ID_W(ID_W)) bus0 ();
    barrett_sched_if #(.N(N), .ID_W(ID_W)) bus1 ();

    assign bus1.req_valid = bus0.req_valid;
    assign bus1.req_data  = bus0.req_data;
    assign bus1.rsp_ready = bus0.rsp_ready;

    barrett_sched #(.N(N), .ID_W(ID_W), .LAT(LAT), .DEPTH(DEPTH), .Q(16'(Q)), .CORRECT(1'b1)) dut0 (
        .clk(clk), .srst_n(srst_n), .bus(bus0), .br_din(br_din0), .br_srst(br_srst0),
        .br_dout(br_dout0), .busy(busy0)
    );

    barrett_sched #(.N(N), .ID_W(ID_W), .LAT(LAT), .DEPTH(DEPTH), .Q(16'(Q)), .CORRECT(1'b0)) dut1 (
        .clk(clk), .srst_n(srst_n), .bus(bus1), .br_din(br_din1), .br_srst(br_srst1),
        .br_dout(br_dout1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reduction pipeline model: partial reduction mod 2Q, result sampled LAT edges after issue.
    logic [15:0] pipe0 [LAT-1];
    logic [15:0] pipe1 [LAT-1];
    assign br_dout0 = pipe0[LAT-2];
    assign br_dout1 = pipe1[LAT-2];

    always @(posedge clk) begin
        for (int i = 0; i < LAT - 1; i++) begin
            if (br_srst0) pipe0[i] <= '0;
            else if (i == 0) pipe0[i] <= 16'(32'(br_din0) % (2 * Q));
            else pipe0[i] <= pipe0[i-1];
            if (br_srst1) pipe1[i] <= '0;
            else if (i == 0) pipe1[i] <= 16'(32'(br_din1) % (2 * Q));
            else pipe1[i] <= pipe1[i-1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Response model: every accepted operand is owed one response, in order, LAT edges later.
    typedef struct {
        logic [15:0] data;
        logic [15:0] raw;
        int          id;
        int          due;
    } exp_t;

    exp_t q[$];
    int   rr = 0;
    int   m_g;
    int   m_idx;
    logic [3:0]  m_er;
    logic        m_ev;
    logic [15:0] m_x;
    exp_t        m_e;

    always @(negedge clk) begin
        m_er = '0;
        m_g  = -1;
        if (srst_n && q.size() < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                m_idx = (rr + k) % N;
                if (m_g < 0 && ((bus0.req_valid >> m_idx) & 4'd1) != 4'd0) m_g = m_idx;
            end
        end
        if (m_g >= 0) m_er = 4'(1) << m_g;
        m_ev = srst_n && q.size() > 0 && q[0].due <= cyc;

        chk("req_ready", 32'(bus0.req_ready), 32'(m_er));
        chk("req_ready_nocorr", 32'(bus1.req_ready), 32'(m_er));
        chk("rsp_valid", 32'(bus0.rsp_valid), 32'(m_ev));
        chk("rsp_valid_nocorr", 32'(bus1.rsp_valid), 32'(m_ev));
        chk("busy", 32'(busy0), 32'(srst_n && q.size() > 0));
        chk("busy_nocorr", 32'(busy1), 32'(srst_n && q.size() > 0));
        chk("br_srst", 32'(br_srst0), 32'(!srst_n));
        if (m_ev) begin
            chk("rsp_data", 32'(bus0.rsp_data), 32'(q[0].data));
            chk("rsp_id", 32'(bus0.rsp_id), 32'(q[0].id));
            chk("rsp_data_nocorr", 32'(bus1.rsp_data), 32'(q[0].raw));
            chk("rsp_id_nocorr", 32'(bus1.rsp_id), 32'(q[0].id));
        end
        if (!srst_n) begin
            chk("rst_rsp_data", 32'(bus0.rsp_data), 32'd0);
            chk("rst_rsp_id", 32'(bus0.rsp_id), 32'd0);
        end else begin
            checks++;
            assert (!(dut0.fifo_push && dut0.fifo_full && !dut0.fifo_pop)) else begin
                failures++;
                $display("FAIL fifo_overflow: push into full FIFO at t=%0t", $time);
            end
        end

        if (!srst_n) begin
            q.delete();
            rr = 0;
        end else begin
            if (m_ev && bus0.rsp_ready) begin
                void'(q.pop_front());
                pops++;
            end
            if (m_g >= 0) begin
                m_x    = 16'(bus0.req_data >> (16 * m_g));
                m_e.data = 16'(32'(m_x) % Q);
                m_e.raw  = 16'(32'(m_x) % (2 * Q));
                m_e.id   = m_g;
                m_e.due  = cyc + 1 + LAT;
                q.push_back(m_e);
                rr = (m_g + 1) % N;
            end
        end
    end

    task automatic drain(input string name);
        int n = 0;
        bus0.req_valid = '0;
        bus0.rsp_ready = 1'b1;
        while (busy0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy0), 32'd0);
    endtask

    typedef struct {
        int          id;
        logic [15:0] x;
        logic [15:0] exp_c;
        logic [15:0] exp_raw;
    } vec_t;

    vec_t tbl[6];
    int   t_iss, n, ng, ni, k, bubbles, p0;

    initial begin
        tbl[0] = '{0, 16'd5000, 16'd1671, 16'd5000};
        tbl[1] = '{1, 16'd3330, 16'd1, 16'd3330};
        tbl[2] = '{2, 16'd0, 16'd0, 16'd0};
        tbl[3] = '{3, 16'd65535, 16'd2284, 16'd5613};
        tbl[4] = '{0, 16'd3329, 16'd0, 16'd3329};
        tbl[5] = '{2, 16'd6657, 16'd3328, 16'd6657};

        srst_n = 1'b0;
        bus0.req_valid = '0;
        bus0.req_data  = '0;
        bus0.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 srst_n = 1'b1;
        @(negedge clk);
        chk("reset_br_din", 32'(br_din0), 32'd0);
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_rsp_valid", 32'(bus0.rsp_valid), 32'd0);

        // Single operations from the vector table.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus0.rsp_ready = 1'b1;
            bus0.req_valid = 4'(1) << tbl[i].id;
            bus0.req_data  = 64'(tbl[i].x) << (16 * tbl[i].id);
            @(negedge clk);
            chk("tbl_req_ready", 32'(bus0.req_ready), 32'(4'(1) << tbl[i].id));
            @(posedge clk);
            #1;
            t_iss = cyc;
            bus0.req_valid = '0;
            @(negedge clk);
            chk("tbl_br_din", 32'(br_din0), 32'(tbl[i].x));
            n = 0;
            while (!bus0.rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("tbl_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
            chk("tbl_latency", 32'(cyc - t_iss), 32'(LAT));
            chk("tbl_rsp_data", 32'(bus0.rsp_data), 32'(tbl[i].exp_c));
            chk("tbl_rsp_raw", 32'(bus1.rsp_data), 32'(tbl[i].exp_raw));
            chk("tbl_rsp_id", 32'(bus0.rsp_id), 32'(tbl[i].id));
        end
        drain("tbl_drain");

        // Round-robin fairness from a fresh reset.
        @(posedge clk);
        #1 srst_n = 1'b0;
        @(posedge clk);
        #1 srst_n = 1'b1;
        bus0.req_data  = {16'd4004, 16'd3003, 16'd2002, 16'd1001};
        bus0.req_valid = 4'hF;
        bus0.rsp_ready = 1'b1;
        ng = 0;
        n  = 0;
        while (ng < 12 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus0.req_ready != '0) begin
                chk("rr_order", 32'(bus0.req_ready), 32'(4'(1) << (ng % 4)));
                ng++;
            end
            @(posedge clk);
            #1;
        end
        bus0.req_valid = '0;
        chk("rr_count", 32'(ng), 32'd12);
        drain("rr_drain");

        // Backpressure: credit stops issue at DEPTH, one pop buys exactly one issue.
        @(posedge clk);
        #1;
        bus0.rsp_ready = 1'b0;
        bus0.req_valid = 4'b0001;
        bus0.req_data  = 64'd777;
        ni = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus0.req_ready[0]) ni++;
            @(posedge clk);
            #1;
        end
        chk("bp_issues", 32'(ni), 32'(DEPTH));
        bus0.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_full_valid", 32'(bus0.rsp_valid), 32'd1);
        chk("bp_no_credit", 32'(bus0.req_ready), 32'd0);
        @(posedge clk);
        #1 bus0.rsp_ready = 1'b0;
        ni = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus0.req_ready[0]) ni++;
            @(posedge clk);
            #1;
        end
        chk("bp_one_more", 32'(ni), 32'd1);
        drain("bp_drain");

        // Back-to-back streaming on requester 2.
        @(posedge clk);
        #1;
        p0 = pops;
        bus0.rsp_ready = 1'b1;
        bus0.req_valid = 4'b0100;
        bus0.req_data  = '0;
        k = 0;
        bubbles = 0;
        n = 0;
        while (k < 100 && n < 400) begin
            @(negedge clk);
            n++;
            if (bus0.req_ready[2]) k++;
            else bubbles++;
            @(posedge clk);
            #1 bus0.req_data = 64'(16'(k * 37)) << 32;
        end
        bus0.req_valid = '0;
        chk("stream_issues", 32'(k), 32'd100);
        chk("stream_bubbles", 32'(bubbles), 32'd0);
        drain("stream_drain");
        chk("stream_responses", 32'(pops - p0), 32'd100);

        // Reset with 5 ops in flight and 3 buffered.
        @(posedge clk);
        #1;
        bus0.rsp_ready = 1'b0;
        bus0.req_valid = 4'b0010;
        bus0.req_data  = 64'h0000_0000_1234_0000;
        ni = 0;
        n  = 0;
        while (ni < 8 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus0.req_ready[1]) ni++;
            @(posedge clk);
            #1;
        end
        bus0.req_valid = '0;
        @(negedge clk);
        chk("mid_busy", 32'(busy0), 32'd1);
        @(posedge clk);
        #1;
        srst_n = 1'b0;
        bus0.req_valid = 4'hF;
        @(negedge clk);
        chk("mid_br_srst", 32'(br_srst0), 32'd1);
        chk("mid_ready_in_reset", 32'(bus0.req_ready), 32'd0);
        @(posedge clk);
        #1 srst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("post_rst_busy", 32'(busy0), 32'd0);
        chk("post_rst_grant0", 32'(bus0.req_ready), 32'd1);
        bus0.rsp_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        drain("mid_drain");

        // Random traffic with occasional resets against the response model.
        repeat (1500) begin
            @(posedge clk);
            #1;
            srst_n         = ($urandom_range(0, 299) != 0);
            bus0.req_valid = 4'($urandom);
            bus0.req_data  = {$urandom, $urandom};
            bus0.rsp_ready = ($urandom_range(0, 9) < 6);
        end
        @(posedge clk);
        #1 srst_n = 1'b1;
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
